spi_txn_arbiter: RTL and testbench

SPI master-side transaction controller that shares one SPI bus between `NREQ` on-chip requesters. It arbitrates round-robin and runs a complete chip-select-framed transaction of `len` bytes for the winner. The SPI mode is 0 (CPOL=0, CPHA=0), MSB first, driving SCK/SSEL/MOSI toward the board's SPI slave. Per-byte transmit handshakes and receive strobes go back to the granted requester.

---
 rtl/spi_txn_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// Round-robin SPI mode-0 master shared by NREQ requesters; runs a framed len-byte transaction for the winner.
// Grant to done is CLK_DIV + N*(1+16*CLK_DIV) + CLK_DIV cycles; requests wait without preemption until the bus is free.
module spi_txn_arbiter #(
   parameter int NREQ    = 2,
   parameter int CLK_DIV = 8,
   parameter int LEN_W   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*LEN_W-1:0]   len,
   output logic [NREQ-1:0]         gnt,
   output logic                    busy,
   input  logic [7:0]              tx_data,
   output logic                    tx_take,
   output logic [7:0]              rx_data,
   output logic                    rx_valid,
   output logic                    done,
   output logic                    SCK,
   output logic                    SSEL,
   output logic                    MOSI,
   input  logic                    MISO
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CW    = $clog2(CLK_DIV);

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, HOLD, GUARD} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               phase;
   logic [2:0]         bit_idx;
   logic [LEN_W-1:0]   rem;
   logic [IDX_W-1:0]   last;
   logic [NREQ-1:0]    gnt_r;
   logic [7:0]         tx_sr;
   logic [7:0]         rx_sr;
   logic               win_vld;
   logic [IDX_W-1:0]   win_idx;
   logic [LEN_W-1:0]   len_sel;
   logic               cnt_end;
   logic               byte_end;
   logic               active;

   assign cnt_end  = (cnt == CW'(CLK_DIV - 1));
   assign byte_end = (state == SHIFT) && phase && cnt_end && (bit_idx == 3'd7);
   assign len_sel  = len[win_idx*LEN_W +: LEN_W];

   // Scan downward so the closest index after 'last' is the final overwrite.
   always_comb begin
      int j;
      j       = 0;
      win_vld = 1'b0;
      win_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = (int'(last) + k) % NREQ;
         if (req[j]) begin
            win_vld = 1'b1;
            win_idx = IDX_W'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_vld) state_nxt = SETUP;
         SETUP:   if (cnt_end) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (byte_end) state_nxt = (rem == LEN_W'(1)) ? HOLD : LOAD;
         HOLD:    if (cnt_end) state_nxt = GUARD;
         GUARD:   if (cnt_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      active  = (state == SETUP) || (state == LOAD) || (state == SHIFT) || (state == HOLD);
      gnt     = active ? gnt_r : '0;
      busy    = (state != IDLE);
      SSEL    = !active;
      SCK     = (state == SHIFT) && phase;
      MOSI    = (state == SHIFT) && tx_sr[7];
      tx_take = (state == LOAD);
      done    = (state == GUARD) && (cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         phase    <= 1'b0;
         bit_idx  <= '0;
         rem      <= '0;
         last     <= IDX_W'(NREQ - 1);
         gnt_r    <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state_nxt != state) begin
            cnt     <= '0;
            phase   <= 1'b0;
            bit_idx <= '0;
         end else if (cnt_end) begin
            cnt <= '0;
            if (state == SHIFT) begin
               phase <= ~phase;
               if (phase) bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            cnt <= cnt + CW'(1);
         end

         if (state == IDLE && win_vld) begin
            gnt_r          <= '0;
            gnt_r[win_idx] <= 1'b1;
            last           <= win_idx;
            rem            <= (len_sel == '0) ? LEN_W'(1) : len_sel;
         end

         if (state == LOAD) tx_sr <= tx_data;

         if (state == SHIFT) begin
            if (!phase && cnt_end) rx_sr <= {rx_sr[6:0], MISO};
            if (phase && cnt_end && bit_idx != 3'd7) tx_sr <= {tx_sr[6:0], 1'b0};
            // Publish one cycle before the final falling edge so the pulse lands in that edge's cycle.
            if (phase && bit_idx == 3'd7 && cnt == CW'(CLK_DIV - 2)) begin
               rx_valid <= 1'b1;
               rx_data  <= rx_sr;
            end
            if (byte_end) rem <= rem - LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with CLK_DIV=4, two requesters, loopback or model-slave MISO.
module tb_spi_txn_arbiter;
   localparam int NREQ = 2;
   localparam int CD   = 4;
   localparam int LW   = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*LW-1:0]   len = '0;
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic [7:0]           tx_data;
   logic                 tx_take;
   logic [7:0]           rx_data;
   logic                 rx_valid;
   logic                 done;
   logic                 SCK;
   logic                 SSEL;
   logic                 MOSI;
   logic                 MISO;

   logic                 lb = 1'b1;
   logic [7:0]           slv_byte = 8'h00;
   int                   sidx = 0;
   logic [7:0]           tx_bytes [0:7];
   int                   tx_idx = 0;

   int n_vec = 0;
   int n_bad = 0;

   int cyc = 0;
   int take_q[$];
   int rxv_q[$];
   logic [7:0] rxd_q[$];
   logic [NREQ-1:0] gnt_q[$];
   int done_cnt = 0, done_cyc = 0, gnt_cyc = 0;
   int ssel_low = 0, ssel_bad = 0, onehot_bad = 0, sck_rise = 0, mosi_bad = 0;
   int ssel_run = 0, gap_min = 1000;
   logic prev_take = 1'b0, prev_sck = 1'b0, prev_mosi = 1'b0, prev_ssel = 1'b1;
   logic [NREQ-1:0] prev_gnt = '0;

   spi_txn_arbiter #(.NREQ(NREQ), .CLK_DIV(CD), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .req(req), .len(len), .gnt(gnt), .busy(busy),
      .tx_data(tx_data), .tx_take(tx_take), .rx_data(rx_data), .rx_valid(rx_valid),
      .done(done), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   assign tx_data = tx_bytes[tx_idx[2:0]];
   assign MISO    = lb ? MOSI : ((sidx < 8) ? slv_byte[7 - sidx] : 1'b0);

   // Mode-0 slave: first bit valid at SSEL fall, next bit after each SCK fall.
   always @(negedge SSEL) sidx = 0;
   always @(negedge SCK) if (!SSEL) sidx = sidx + 1;

   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (prev_take) tx_idx = tx_idx + 1;
      prev_take = tx_take;
      if (tx_take) take_q.push_back(cyc);
      if (rx_valid) begin
         rxv_q.push_back(cyc);
         rxd_q.push_back(rx_data);
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (gnt != '0 && prev_gnt == '0) begin
         gnt_cyc = cyc;
         gnt_q.push_back(gnt);
      end
      if (gnt != '0 && !$onehot(gnt)) onehot_bad = onehot_bad + 1;
      if (!SSEL) ssel_low = ssel_low + 1;
      if (gnt != '0 && SSEL) ssel_bad = ssel_bad + 1;
      if (SCK && !prev_sck) sck_rise = sck_rise + 1;
      if (MOSI !== prev_mosi && SCK) mosi_bad = mosi_bad + 1;
      if (SSEL) ssel_run = ssel_run + 1;
      if (!SSEL && prev_ssel) begin
         if (ssel_run < gap_min) gap_min = ssel_run;
         ssel_run = 0;
      end
      prev_sck  = SCK;
      prev_mosi = MOSI;
      prev_ssel = SSEL;
      prev_gnt  = gnt;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      take_q.delete();
      rxv_q.delete();
      rxd_q.delete();
      gnt_q.delete();
      ssel_low = 0; ssel_bad = 0; onehot_bad = 0; sck_rise = 0; mosi_bad = 0;
      gap_min = 1000;
      tx_idx = 0;
   endtask

   task automatic wait_gnt(input string tag, input logic [NREQ-1:0] exp, input int budget);
      int t = 0;
      while (gnt == '0 && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(tag, 32'(gnt), 32'(exp));
   endtask

   task automatic wait_done(input string tag, input int target, input int budget);
      int t = 0;
      while (done_cnt < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      check(tag, done_cnt, target);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int snap_done, snap_rxv, t;
      for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ssel", 32'(SSEL), 1);
      check("rst_sck", 32'(SCK), 0);
      check("rst_mosi", 32'(MOSI), 0);
      check("rst_rx_data", 32'(rx_data), 0);
      check("rst_pulses", 32'({tx_take, rx_valid, done}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single byte, loopback
      clear_logs();
      tx_bytes[0] = 8'hA5;
      len = 8'h01;
      req = 2'b01;
      wait_gnt("t1_gnt", 2'b01, 50);
      req = 2'b00;
      wait_done("t1_done", 1, 500);
      repeat (8) @(negedge clk);
      check("t1_takes", take_q.size(), 1);
      check("t1_gnt_to_take", take_q[0] - gnt_cyc, CD);
      check("t1_take_to_rxv", rxv_q[0] - take_q[0], 16 * CD);
      check("t1_rx", 32'(rxd_q[0]), 32'hA5);
      check("t1_gnt_to_done", done_cyc - gnt_cyc, 73);
      check("t1_ssel_low", ssel_low, 73);

      // Three bytes, loopback
      clear_logs();
      tx_bytes[0] = 8'h05; tx_bytes[1] = 8'h03; tx_bytes[2] = 8'h7E;
      len = 8'h03;
      req = 2'b01;
      wait_gnt("t2_gnt", 2'b01, 50);
      req = 2'b00;
      wait_done("t2_done", 2, 1000);
      repeat (8) @(negedge clk);
      check("t2_takes", take_q.size(), 3);
      check("t2_take_gap0", take_q[1] - take_q[0], 65);
      check("t2_take_gap1", take_q[2] - take_q[1], 65);
      check("t2_rx0", 32'(rxd_q[0]), 32'h05);
      check("t2_rx1", 32'(rxd_q[1]), 32'h03);
      check("t2_rx2", 32'(rxd_q[2]), 32'h7E);
      check("t2_ssel_rise", ssel_bad, 0);
      check("t2_sck_rises", sck_rise, 24);

      // Contention from a fresh reset
      pulse_reset();
      done_cnt = 0;
      clear_logs();
      tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; tx_bytes[3] = 8'h44;
      len = 8'h11;
      req = 2'b11;
      wait_done("t3_done", 4, 2000);
      req = 2'b00;
      repeat (20) @(negedge clk);
      check("t3_gnt0", 32'(gnt_q[0]), 32'b01);
      check("t3_gnt1", 32'(gnt_q[1]), 32'b10);
      check("t3_gnt2", 32'(gnt_q[2]), 32'b01);
      check("t3_gnt3", 32'(gnt_q[3]), 32'b10);
      check("t3_onehot", onehot_bad, 0);
      check("t3_gap_ok", 32'(gap_min >= CD), 1);

      // Mode-0 against a model slave
      clear_logs();
      lb = 1'b0;
      slv_byte = 8'h0A;
      tx_bytes[0] = 8'h3C;
      len = 8'h01;
      req = 2'b01;
      wait_gnt("t4_gnt", 2'b01, 50);
      req = 2'b00;
      wait_done("t4_done", 5, 500);
      repeat (4) @(negedge clk);
      check("t4_rx", 32'(rxd_q[0]), 32'h0A);
      check("t4_mosi_sck_high", mosi_bad, 0);
      check("t4_sck_rises", sck_rise, 8);
      lb = 1'b1;

      // Reset during bit 4
      clear_logs();
      tx_bytes[0] = 8'hC3;
      req = 2'b01;
      wait_gnt("t5_gnt", 2'b01, 50);
      t = 0;
      while (take_q.size() == 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("t5_take_seen", take_q.size(), 1);
      repeat (27) @(negedge clk);
      snap_done = done_cnt;
      snap_rxv  = rxv_q.size();
      rst = 1'b1;
      @(negedge clk);
      check("t5_ssel", 32'(SSEL), 1);
      check("t5_sck", 32'(SCK), 0);
      check("t5_gnt", 32'(gnt), 0);
      rst = 1'b0;
      @(negedge clk);
      wait_gnt("t5_regnt", 2'b01, 50);
      check("t5_no_done", done_cnt, snap_done);
      check("t5_no_rxv", rxv_q.size(), snap_rxv);
      req = 2'b00;
      wait_done("t5_done", snap_done + 1, 500);
      repeat (8) @(negedge clk);

      // Zero length on requester 1
      clear_logs();
      tx_bytes[0] = 8'h5A;
      len = 8'h01;
      req = 2'b10;
      wait_gnt("t6_gnt", 2'b10, 50);
      req = 2'b00;
      wait_done("t6_done", done_cnt + 1, 500);
      repeat (8) @(negedge clk);
      check("t6_takes", take_q.size(), 1);
      check("t6_rxv", rxv_q.size(), 1);
      check("t6_rx", 32'(rxd_q[0]), 32'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
